// File: rtl/weather_code_transmitter.sv
// Sensor-side transmitter: mirrors the station receiver's registers and emits
// the 3-bit code stream (111/010/101, 000 idle) that walks them to the targets.
module weather_code_transmitter #(
  parameter int HOUR_START = 12,
  parameter int HOUR_END   = 16,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] current_hour,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic [5:0] target_temp,
  input  logic [5:0] target_hum,
  input  logic [4:0] target_wind,
  output logic [2:0] signal,
  output logic       busy,
  output logic       done,
  output logic [5:0] mirror_temp,
  output logic [5:0] mirror_hum,
  output logic [4:0] mirror_wind
);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_SEND, S_GAP} state_t;

  localparam logic [1:0] CH_TEMP = 2'd0;
  localparam logic [1:0] CH_HUM  = 2'd1;
  localparam logic [1:0] CH_WIND = 2'd2;
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state_q, state_d;
  logic       eval_q, eval_d;
  logic [2:0] pend_q, pend_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [5:0] tgt_temp_q, tgt_temp_d;
  logic [5:0] tgt_hum_q, tgt_hum_d;
  logic [4:0] tgt_wind_q, tgt_wind_d;
  logic [5:0] mir_temp_q, mir_temp_d;
  logic [5:0] mir_hum_q, mir_hum_d;
  logic [4:0] mir_wind_q, mir_wind_d;
  logic [2:0] signal_q, signal_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [4:0] wind_res;
  logic [2:0] pend_now;
  logic       window_open;
  logic [1:0] cand0, cand1, cand2, chosen;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_WIND) ? CH_TEMP : ch + 2'd1;
  endfunction

  function automatic logic [2:0] ch_code(input logic [1:0] ch);
    case (ch)
      CH_TEMP: ch_code = 3'b111;
      CH_HUM:  ch_code = 3'b010;
      CH_WIND: ch_code = 3'b101;
      default: ch_code = 3'b000;
    endcase
  endfunction

  // Wind moves only in steps of 8, so a residue below 8 is as close as it gets.
  assign wind_res    = tgt_wind_q - mir_wind_q;
  assign pend_now    = {wind_res >= 5'd8, mir_hum_q != tgt_hum_q, mir_temp_q != tgt_temp_q};
  assign window_open = (current_hour >= 5'(HOUR_START)) && (current_hour <= 5'(HOUR_END));

  assign cand0  = ptr_q;
  assign cand1  = next_ch(cand0);
  assign cand2  = next_ch(cand1);
  assign chosen = pend_q[cand0] ? cand0 : (pend_q[cand1] ? cand1 : cand2);

  always_comb begin
    state_d    = state_q;
    eval_d     = eval_q;
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gap_cnt_d  = gap_cnt_q;
    tgt_temp_d = tgt_temp_q;
    tgt_hum_d  = tgt_hum_q;
    tgt_wind_d = tgt_wind_q;
    mir_temp_d = mir_temp_q;
    mir_hum_d  = mir_hum_q;
    mir_wind_d = mir_wind_q;
    signal_d   = 3'b000;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (target_valid && target_ready) begin
          tgt_temp_d = target_temp;
          tgt_hum_d  = target_hum;
          tgt_wind_d = target_wind;
          busy_d     = 1'b1;
          eval_d     = 1'b0;
          state_d    = S_PICK;
        end
      end
      // First PICK cycle registers the pending set, later cycles act on it.
      S_PICK: begin
        if (!eval_q) begin
          pend_d = pend_now;
          eval_d = 1'b1;
        end else if (pend_q == 3'b000) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (window_open) begin
          sel_d    = chosen;
          signal_d = ch_code(chosen);
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        case (sel_q)
          CH_TEMP: mir_temp_d = mir_temp_q + 6'd3;
          CH_HUM:  mir_hum_d  = mir_hum_q + 6'd1;
          default: mir_wind_d = mir_wind_q + 5'd8;
        endcase
        ptr_d = next_ch(sel_q);
        if (GAP == 0) begin
          eval_d  = 1'b0;
          state_d = S_PICK;
        end else begin
          gap_cnt_d = GAP_LAST;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          eval_d  = 1'b0;
          state_d = S_PICK;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      eval_q     <= 1'b0;
      pend_q     <= 3'b000;
      ptr_q      <= CH_TEMP;
      sel_q      <= CH_TEMP;
      gap_cnt_q  <= 4'd0;
      tgt_temp_q <= 6'd43;
      tgt_hum_q  <= 6'd52;
      tgt_wind_q <= 5'd19;
      mir_temp_q <= 6'd43;
      mir_hum_q  <= 6'd52;
      mir_wind_q <= 5'd19;
      signal_q   <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      eval_q     <= eval_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gap_cnt_q  <= gap_cnt_d;
      tgt_temp_q <= tgt_temp_d;
      tgt_hum_q  <= tgt_hum_d;
      tgt_wind_q <= tgt_wind_d;
      mir_temp_q <= mir_temp_d;
      mir_hum_q  <= mir_hum_d;
      mir_wind_q <= mir_wind_d;
      signal_q   <= signal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign target_ready = (state_q == S_IDLE) && !rst;
  assign signal       = signal_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mirror_temp  = mir_temp_q;
  assign mirror_hum   = mir_hum_q;
  assign mirror_wind  = mir_wind_q;

endmodule

// File: tb/tb_weather_code_transmitter.sv
// Bench for weather_code_transmitter: table of target bundles with hand-derived
// code counts, orders and final mirrors, plus window and mid-run reset sequences.
module tb_weather_code_transmitter;

  logic       clk;
  logic       rst;
  logic [4:0] current_hour;
  logic       target_valid;
  logic       target_ready;
  logic [5:0] target_temp;
  logic [5:0] target_hum;
  logic [4:0] target_wind;
  logic [2:0] signal;
  logic       busy;
  logic       done;
  logic [5:0] mirror_temp;
  logic [5:0] mirror_hum;
  logic [4:0] mirror_wind;

  weather_code_transmitter #(.HOUR_START(12), .HOUR_END(16), .GAP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .current_hour (current_hour),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .target_temp  (target_temp),
    .target_hum   (target_hum),
    .target_wind  (target_wind),
    .signal       (signal),
    .busy         (busy),
    .done         (done),
    .mirror_temp  (mirror_temp),
    .mirror_hum   (mirror_hum),
    .mirror_wind  (mirror_wind)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [2:0] got_q[$];
  int done_cnt, lat, bad, timed_out, busy_first;

  typedef struct {
    logic [5:0] t;
    logic [5:0] h;
    logic [4:0] w;
    int         nt;
    int         nh;
    int         nw;
    logic [8:0] seq;
    logic [5:0] mt;
    logic [5:0] mh;
    logic [4:0] mw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one target bundle and watches the code stream until done (bounded).
  task automatic run_target(input logic [5:0] t, input logic [5:0] h, input logic [4:0] w);
    int idx;
    logic [2:0] prev;
    got_q.delete();
    done_cnt = 0; lat = -1; bad = 0; timed_out = 0; busy_first = 0;
    @(negedge clk);
    target_temp = t; target_hum = h; target_wind = w; target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
    prev = 3'b000;
    idx = 1;
    forever begin
      if (idx == 1) busy_first = int'(busy);
      if (!(signal inside {3'b000, 3'b111, 3'b010, 3'b101})) bad++;
      if (signal != 3'b000) begin
        got_q.push_back(signal);
        if (lat < 0) lat = idx;
        if (prev != 3'b000) bad++;
      end
      prev = signal;
      if (done) begin
        done_cnt++;
        break;
      end
      if (idx > 2000) begin
        timed_out = 1;
        break;
      end
      idx++;
      @(negedge clk);
    end
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic check_run(input string tag, input vec_t v, input int exp_lat);
    int nt, nh, nw;
    logic [8:0] seq;
    nt = 0; nh = 0; nw = 0; seq = 9'd0;
    foreach (got_q[i]) begin
      if (got_q[i] == 3'b111) nt++;
      if (got_q[i] == 3'b010) nh++;
      if (got_q[i] == 3'b101) nw++;
      if (i < 3) seq[8 - 3*i -: 3] = got_q[i];
    end
    chk({tag, " timeout"}, timed_out, 0);
    chk({tag, " n_temp"}, nt, v.nt);
    chk({tag, " n_hum"}, nh, v.nh);
    chk({tag, " n_wind"}, nw, v.nw);
    chk({tag, " order"}, int'(seq), int'(v.seq));
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " spacing/legal"}, bad, 0);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_during"}, busy_first, 1);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " ready_after"}, int'(target_ready), 1);
    chk({tag, " mirror_temp"}, int'(mirror_temp), int'(v.mt));
    chk({tag, " mirror_hum"}, int'(mirror_hum), int'(v.mh));
    chk({tag, " mirror_wind"}, int'(mirror_wind), int'(v.mw));
  endtask

  initial begin
    vecs[0] = '{6'd46, 6'd52, 5'd19, 1, 0, 0, {3'b111, 3'b000, 3'b000}, 6'd46, 6'd52, 5'd19};
    vecs[1] = '{6'd43, 6'd54, 5'd27, 0, 2, 1, {3'b010, 3'b101, 3'b010}, 6'd43, 6'd54, 5'd27};
    vecs[2] = '{6'd40, 6'd52, 5'd19, 63, 0, 0, {3'b111, 3'b111, 3'b111}, 6'd40, 6'd52, 5'd19};
    vecs[3] = '{6'd43, 6'd52, 5'd20, 0, 0, 0, 9'd0, 6'd43, 6'd52, 5'd19};
    vecs[4] = '{6'd49, 6'd50, 5'd3, 2, 62, 2, {3'b111, 3'b010, 3'b101}, 6'd49, 6'd50, 5'd3};
    vecs[5] = '{6'd43, 6'd52, 5'd31, 0, 0, 1, {3'b101, 3'b000, 3'b000}, 6'd43, 6'd52, 5'd27};

    rst = 1'b1; current_hour = 5'd12; target_valid = 1'b0;
    target_temp = '0; target_hum = '0; target_wind = '0;
    repeat (2) @(negedge clk);
    chk("rst ready_low", int'(target_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst signal", int'(signal), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst ready_high", int'(target_ready), 1);
    chk("rst mirror_temp", int'(mirror_temp), 43);
    chk("rst mirror_hum", int'(mirror_hum), 52);
    chk("rst mirror_wind", int'(mirror_wind), 19);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_target(vecs[i].t, vecs[i].h, vecs[i].w);
      check_run($sformatf("vec%0d", i), vecs[i], (vecs[i].nt + vecs[i].nh + vecs[i].nw) > 0 ? 3 : -1);
    end

    // Window closed: target held pending with a quiet bus, then released.
    begin
      int early;
      early = 0;
      do_reset();
      current_hour = 5'd10;
      @(negedge clk);
      target_temp = 6'd46; target_hum = 6'd52; target_wind = 5'd19; target_valid = 1'b1;
      @(negedge clk);
      target_valid = 1'b0;
      repeat (20) begin
        if (signal != 3'b000) early++;
        @(negedge clk);
      end
      chk("window quiet", early, 0);
      chk("window busy", int'(busy), 1);
      current_hour = 5'd12;
      @(negedge clk);
      chk("window first_code", int'(signal), 3'b111);
      @(negedge clk);
      chk("window code_len", int'(signal), 0);
      repeat (5) @(negedge clk);
      chk("window mirror_temp", int'(mirror_temp), 46);
      chk("window busy_after", int'(busy), 0);
    end

    // Reset in the middle of a long run, then a normal transfer.
    begin
      do_reset();
      @(negedge clk);
      target_temp = 6'd40; target_hum = 6'd52; target_wind = 5'd19; target_valid = 1'b1;
      @(negedge clk);
      target_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst busy_before", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst signal", int'(signal), 0);
      chk("midrst mirror_temp", int'(mirror_temp), 43);
      chk("midrst mirror_hum", int'(mirror_hum), 52);
      chk("midrst mirror_wind", int'(mirror_wind), 19);
      chk("midrst busy", int'(busy), 0);
      chk("midrst ready_low", int'(target_ready), 0);
      rst = 1'b0;
      run_target(vecs[0].t, vecs[0].h, vecs[0].w);
      check_run("midrst_next", vecs[0], 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
